// File: rtl/seq_detect_param_if.sv
// Signal bundle for seq_detect_param: serial stream, configuration and status.
// The optional don't-care mask exists only when SEQ_DET_MASK_EN is defined.
interface seq_detect_param_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
);
    logic               in_valid;
    logic               inp_bit;
    logic               cfg_load;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   pat_len;
    logic               overlap_en;
    logic               clear;
    logic               seq_seen;
    logic [CNT_W-1:0]   match_count;
    logic               busy_cfg;
`ifdef SEQ_DET_MASK_EN
    logic [MAX_LEN-1:0] mask;
`endif

    modport master (
`ifdef SEQ_DET_MASK_EN
        output mask,
`endif
        output in_valid, inp_bit, cfg_load, pattern, pat_len, overlap_en, clear,
        input  seq_seen, match_count, busy_cfg
    );

    modport slave (
`ifdef SEQ_DET_MASK_EN
        input  mask,
`endif
        input  in_valid, inp_bit, cfg_load, pattern, pat_len, overlap_en, clear,
        output seq_seen, match_count, busy_cfg
    );
endinterface

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial pattern detector with saturating match counter.
// Define SEQ_DET_MASK_EN to add per-position don't-care masking of the pattern.
module seq_detect_param #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic            clk,
    input  logic            reset,
    seq_detect_param_if.slave bus
);
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] pattern_r;
    logic [LEN_W-1:0]   len_r;
    logic               ovl_r;
    logic [MAX_LEN-1:0] history;
    logic [MAX_LEN-1:0] hist_nxt;
    logic [MAX_LEN-1:0] len_mask;
    logic [MAX_LEN-1:0] care;
    logic [LEN_W-1:0]   fill;
    logic [CNT_W-1:0]   count_r;
    logic               seen_r;
    logic               accept;
    logic               fill_ok;
    logic               match;
`ifdef SEQ_DET_MASK_EN
    logic [MAX_LEN-1:0] mask_r;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] n);
        return (n > MAX_L) ? MAX_L : n;
    endfunction

    // Match evaluation on the incoming bit, against the shifted history
    always_comb begin
        hist_nxt = MAX_LEN'({history, bus.inp_bit});
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LEN_W'(i) < len_r);
        end
`ifdef SEQ_DET_MASK_EN
        care = len_mask & ~mask_r;
`else
        care = len_mask;
`endif
        accept  = bus.in_valid & ~bus.clear & ~bus.cfg_load;
        fill_ok = ((LEN_W+1)'(fill) + 1'b1) >= (LEN_W+1)'(len_r);
        match   = accept && (len_r != '0) && fill_ok &&
                  (((hist_nxt ^ pattern_r) & care) == '0);
    end

    // Configuration registers, loaded even when clear is asserted alongside
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pattern_r <= '0;
            len_r     <= '0;
            ovl_r     <= 1'b1;
`ifdef SEQ_DET_MASK_EN
            mask_r    <= '0;
`endif
        end else if (bus.cfg_load) begin
            pattern_r <= bus.pattern;
            len_r     <= clamp_len(bus.pat_len);
            ovl_r     <= bus.overlap_en;
`ifdef SEQ_DET_MASK_EN
            mask_r    <= bus.mask;
`endif
        end
    end

    // History, fill, count and match pulse; clear beats cfg_load beats data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            history <= '0;
            fill    <= '0;
            count_r <= '0;
            seen_r  <= 1'b0;
        end else if (bus.clear) begin
            history <= '0;
            fill    <= '0;
            count_r <= '0;
            seen_r  <= 1'b0;
        end else if (bus.cfg_load) begin
            history <= '0;
            fill    <= '0;
            seen_r  <= 1'b0;
        end else if (bus.in_valid) begin
            history <= hist_nxt;
            seen_r  <= match;
            if (match && !ovl_r) begin
                fill <= '0;
            end else if (fill != MAX_L) begin
                fill <= fill + 1'b1;
            end
            if (match) begin
                count_r <= sat_inc(count_r);
            end
        end else begin
            seen_r <= 1'b0;
        end
    end

    assign bus.seq_seen    = seen_r;
    assign bus.match_count = count_r;
    assign bus.busy_cfg    = (len_r == '0);
endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param: vector table, directed corner cases
// and randomized traffic against a bit-queue reference model.
module tb_seq_detect_param;
    localparam int ML = 8;
    localparam int LW = 4;
    localparam int CW = 4;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    seq_detect_param_if #(.MAX_LEN(ML), .LEN_W(LW), .CNT_W(CW)) bus ();

    seq_detect_param #(.MAX_LEN(ML), .LEN_W(LW), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: bits accepted since the last restart, and config
    logic [ML-1:0] m_pat;
    logic [ML-1:0] m_mask;
    int            m_len;
    logic          m_ovl;
    bit            q[$];
    int            since;
    logic          e_seen;
    int            e_cnt;

    task automatic model_reset();
        m_pat = '0; m_mask = '0; m_len = 0; m_ovl = 1'b1;
        q.delete(); since = 0; e_seen = 1'b0; e_cnt = 0;
    endtask

    function automatic bit model_hit();
        if (m_len == 0 || since < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            if (!m_mask[k] && (q[q.size()-1-k] != m_pat[k])) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_load();
        m_pat = bus.pattern;
        m_len = (int'(bus.pat_len) > ML) ? ML : int'(bus.pat_len);
        m_ovl = bus.overlap_en;
`ifdef SEQ_DET_MASK_EN
        m_mask = bus.mask;
`else
        m_mask = '0;
`endif
    endtask

    task automatic model_step();
        bit hit;
        if (bus.clear) begin
            if (bus.cfg_load) model_load();
            q.delete(); since = 0; e_cnt = 0; e_seen = 1'b0;
        end else if (bus.cfg_load) begin
            model_load();
            q.delete(); since = 0; e_seen = 1'b0;
        end else if (bus.in_valid) begin
            q.push_back(bus.inp_bit);
            if (q.size() > 32) void'(q.pop_front());
            since++;
            hit = model_hit();
            e_seen = hit;
            if (hit) begin
                if (e_cnt < (1 << CW) - 1) e_cnt++;
                if (!m_ovl) since = 0;
            end
        end else begin
            e_seen = 1'b0;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic b, input logic c, input logic l,
                         input logic [ML-1:0] p, input logic [LW-1:0] n, input logic o,
                         input logic [ML-1:0] mk);
        bus.in_valid = v; bus.inp_bit = b; bus.clear = c; bus.cfg_load = l;
        bus.pattern = p; bus.pat_len = n; bus.overlap_en = o;
`ifdef SEQ_DET_MASK_EN
        bus.mask = mk;
`endif
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Data cycle with junk on the config inputs, which must be ignored
    task automatic bitc(input logic v, input logic b);
        drive(v, b, 1'b0, 1'b0, ML'($urandom), LW'($urandom), 1'($urandom), ML'($urandom));
    endtask

    task automatic chk_model(input string nm);
        chk({nm, "_seen"}, 32'(bus.seq_seen), 32'(e_seen));
        chk({nm, "_cnt"}, 32'(bus.match_count), 32'(e_cnt));
        chk({nm, "_busy"}, 32'(bus.busy_cfg), 32'(m_len == 0));
    endtask

    typedef struct {
        logic          v, b, c, l;
        logic [ML-1:0] p;
        logic [LW-1:0] n;
        logic          o;
        logic          es;
        int            ec;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic b, input logic c, input logic l,
                                input logic [ML-1:0] p, input logic [LW-1:0] n,
                                input logic o, input logic es, input int ec);
        vec_t r;
        r.v = v; r.b = b; r.c = c; r.l = l; r.p = p; r.n = n; r.o = o; r.es = es; r.ec = ec;
        return r;
    endfunction

    vec_t tbl[$];

    initial begin
        logic [7:0] stream;
        int         exp6;
        total = 0; bad = 0;
        bus.in_valid = 0; bus.inp_bit = 0; bus.clear = 0; bus.cfg_load = 0;
        bus.pattern = '0; bus.pat_len = '0; bus.overlap_en = 0;
`ifdef SEQ_DET_MASK_EN
        bus.mask = '0;
`endif
        model_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seen", 32'(bus.seq_seen), 0);
        chk("rst_cnt", 32'(bus.match_count), 0);
        chk("rst_busy", 32'(bus.busy_cfg), 1);
        reset = 1'b1;

        // Plan 1: 1011 overlapping over 1,0,1,1,0,1,1
        tbl.push_back(mk(0,0,0,1, 8'b00001011, 4, 1, 0, 0));
        tbl.push_back(mk(1,1,0,0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,0,0,0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,1,0,0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,1,0,0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1,0,0,0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1,1,0,0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1,1,0,0, 0, 0, 0, 1, 2));
        // Plan 2: 101 overlapping, then non-overlapping
        tbl.push_back(mk(0,0,1,0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,1,0,1, 8'b101, 3, 1, 0, 0));
        tbl.push_back(mk(1,1,0,0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,0,0,0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,1,0,0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1,0,0,0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1,1,0,0, 0, 0, 0, 1, 2));
        tbl.push_back(mk(0,0,1,1, 8'b101, 3, 0, 0, 0));
        tbl.push_back(mk(1,1,0,0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,0,0,0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,1,0,0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1,0,0,0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1,1,0,0, 0, 0, 0, 0, 1));
        // Plan 3: 1011 with idle gaps between valid bits
        tbl.push_back(mk(0,0,1,1, 8'b1011, 4, 1, 0, 0));
        tbl.push_back(mk(1,1,0,0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0,1,0,0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,0,0,0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0,1,0,0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,1,0,0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0,1,0,0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,1,0,0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0,1,0,0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0,0,0,0, 0, 0, 0, 0, 1));

        foreach (tbl[i]) begin
            if (tbl[i].l || tbl[i].c)
                drive(tbl[i].v, tbl[i].b, tbl[i].c, tbl[i].l, tbl[i].p, tbl[i].n, tbl[i].o, '0);
            else
                bitc(tbl[i].v, tbl[i].b);
            chk($sformatf("tbl%0d_seen", i), 32'(bus.seq_seen), 32'(tbl[i].es));
            chk($sformatf("tbl%0d_cnt", i), 32'(bus.match_count), 32'(tbl[i].ec));
        end

        // Plan 4: length-1 pattern, saturation at 15, then clear
        drive(1, 1, 1, 1, 8'b1, 1, 1, '0);
        chk("sat_ld_cnt", 32'(bus.match_count), 0);
        for (int k = 1; k <= 20; k++) begin
            bitc(1, 1);
            chk($sformatf("sat%0d_cnt", k), 32'(bus.match_count), 32'((k > 15) ? 15 : k));
            chk($sformatf("sat%0d_seen", k), 32'(bus.seq_seen), 1);
        end
        drive(1, 1, 1, 0, '0, '0, 0, '0);
        chk("clr_cnt", 32'(bus.match_count), 0);
        chk("clr_seen", 32'(bus.seq_seen), 0);

        // Plan 5: reset mid-stream drops partial history
        drive(0, 0, 0, 1, 8'b1011, 4, 1, '0);
        bitc(1, 1); bitc(1, 0); bitc(1, 1);
        bus.in_valid = 0;
        reset = 1'b0;
        #2;
        model_reset();
        chk("mid_rst_busy", 32'(bus.busy_cfg), 1);
        chk("mid_rst_cnt", 32'(bus.match_count), 0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        drive(0, 0, 0, 1, 8'b1011, 4, 1, '0);
        bitc(1, 1);
        chk("post_rst_nomatch", 32'(bus.seq_seen), 0);
        bitc(1, 1); bitc(1, 0); bitc(1, 1); bitc(1, 1);
        chk("post_rst_match", 32'(bus.seq_seen), 1);
        chk_model("post_rst");
        drive(0, 0, 0, 1, 8'b0, 0, 1, '0);
        chk("len0_busy", 32'(bus.busy_cfg), 1);
        for (int k = 0; k < 30; k++) begin
            bitc(1, 1'($urandom));
            chk("len0_seen", 32'(bus.seq_seen), 0);
        end

        // Length above MAX_LEN clamps to 8
        stream = 8'b10110010;
        drive(0, 0, 1, 1, stream, 12, 1, '0);
        for (int k = 7; k >= 0; k--) begin
            bitc(1, stream[k]);
            chk("clamp_seen", 32'(bus.seq_seen), 32'(k == 0));
        end
        chk_model("clamp");

        // Plan 6: masked position makes 1111 match 1011
        drive(0, 0, 1, 1, 8'b1011, 4, 0, 8'b0100);
        for (int k = 0; k < 4; k++) bitc(1, 1);
        bitc(1, 1); bitc(1, 0); bitc(1, 1); bitc(1, 1);
`ifdef SEQ_DET_MASK_EN
        exp6 = 2;
`else
        exp6 = 1;
`endif
        chk("mask_cnt", 32'(bus.match_count), 32'(exp6));
        chk_model("mask");

        // Randomized traffic against the reference model
        for (int k = 0; k < 1500; k++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                drive(1'($urandom), 1'($urandom), 1, 1'($urandom), ML'($urandom),
                      LW'($urandom_range(1, 4)), 1'($urandom), ML'($urandom));
            end else if (r < 6) begin
                drive(1'($urandom), 1'($urandom), 0, 1, ML'($urandom),
                      ($urandom_range(0, 9) < 7) ? LW'($urandom_range(1, 4)) : LW'($urandom),
                      1'($urandom), ($urandom_range(0, 1) == 0) ? '0 : ML'($urandom));
            end else begin
                bitc(($urandom_range(0, 9) < 8), 1'($urandom));
            end
            chk_model($sformatf("rnd%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
